// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC3 unified-memory arbiter.
package lc3_mem_pkg;

  localparam int WORD_W = 16;

  // Arbiter sequencing: choose a port, wait on memory, report completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Which core channel owns the current memory transaction.
  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } mem_port_t;

endpackage

// File: rtl/lc3_mem_wait_timer.sv
// Counts cycles spent waiting on memory and flags the abort point.
// The count clears whenever run is low, so every transaction starts at 0.
module lc3_mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;

  // Count BUSY cycles; hold at the last value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LAST) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign expire = run && (wait_cnt == LAST);

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares one memory port between the LC3 fetch and data channels.
// Data has priority; a fetch that has watched STARVE_LIMIT data grants go by
// is forced through next. Transactions never acknowledged within TIMEOUT
// BUSY cycles are aborted and reported with mem_err.
//
// Handshake: instr_req/data_req are levels held until the matching one-cycle
// complete_* pulse; the requester drops req no later than the cycle after.
// mem_req stays high for the whole BUSY window and memory answers with a
// single-cycle mem_ack carrying mem_dout.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [WORD_W-1:0] instr_addr,
  output logic              complete_instr,
  output logic [WORD_W-1:0] Instr_dout,
  input  logic              data_req,
  input  logic              data_rd,
  input  logic [WORD_W-1:0] data_addr,
  input  logic [WORD_W-1:0] data_din,
  output logic              complete_data,
  output logic [WORD_W-1:0] Data_dout,
  output logic              mem_req,
  output logic              mem_rd,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_din,
  input  logic [WORD_W-1:0] mem_dout,
  input  logic              mem_ack,
  output logic              mem_err
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state;
  mem_port_t     grant_port;
  logic [SW-1:0] starve_cnt;
  logic          timer_run;
  logic          timer_expire;

  assign timer_run = (state == BUSY);

  lc3_mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (timer_run),
    .expire(timer_expire)
  );

  // Arbitration FSM with all datapath latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant_port     <= PORT_INSTR;
      starve_cnt     <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      mem_err        <= 1'b0;
      mem_req        <= 1'b0;
      mem_rd         <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
      Instr_dout     <= '0;
      Data_dout      <= '0;
    end else begin
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      mem_err        <= 1'b0;

      case (state)
        IDLE: begin
          if (instr_req && (!data_req || starve_cnt == STARVE_MAX)) begin
            // Fetch wins: either alone, or the starvation guard has tripped.
            grant_port <= PORT_INSTR;
            mem_rd     <= 1'b1;
            mem_addr   <= instr_addr;
            mem_din    <= '0;
            mem_req    <= 1'b1;
            starve_cnt <= '0;
            state      <= BUSY;
          end else if (data_req) begin
            grant_port <= PORT_DATA;
            mem_rd     <= data_rd;
            mem_addr   <= data_addr;
            mem_din    <= data_din;
            mem_req    <= 1'b1;
            state      <= BUSY;
            // Only data grants that overtake a waiting fetch count.
            if (!instr_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end

        BUSY: begin
          if (mem_ack) begin
            // An ack on the final wait cycle still counts as success.
            if (mem_rd) begin
              if (grant_port == PORT_DATA) Data_dout  <= mem_dout;
              else                         Instr_dout <= mem_dout;
            end
            mem_req <= 1'b0;
            if (grant_port == PORT_DATA) complete_data  <= 1'b1;
            else                         complete_instr <= 1'b1;
            state <= RESP;
          end else if (timer_expire) begin
            // Abort: a failed read returns zero so stale data is not reused.
            if (mem_rd) begin
              if (grant_port == PORT_DATA) Data_dout  <= '0;
              else                         Instr_dout <= '0;
            end
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            if (grant_port == PORT_DATA) complete_data  <= 1'b1;
            else                         complete_instr <= 1'b1;
            state <= RESP;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: table of single transactions, then hand-written
// sequences for arbitration order, starvation guard and mid-BUSY reset.
module tb_lc3_mem_arbiter;

  localparam int STARVE_LIMIT = 3;
  localparam int TIMEOUT      = 64;
  localparam int NO_ACK       = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [15:0] instr_addr;
  logic        complete_instr;
  logic [15:0] Instr_dout;
  logic        data_req;
  logic        data_rd;
  logic [15:0] data_addr;
  logic [15:0] data_din;
  logic        complete_data;
  logic [15:0] Data_dout;
  logic        mem_req;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_ack;
  logic        mem_err;

  lc3_mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_req     (instr_req),
    .instr_addr    (instr_addr),
    .complete_instr(complete_instr),
    .Instr_dout    (Instr_dout),
    .data_req      (data_req),
    .data_rd       (data_rd),
    .data_addr     (data_addr),
    .data_din      (data_din),
    .complete_data (complete_data),
    .Data_dout     (Data_dout),
    .mem_req       (mem_req),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .mem_ack       (mem_ack),
    .mem_err       (mem_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int vec_cnt  = 0;
  int fail_cnt = 0;
  logic [17:0] exp_q[$];    // {port(1=data), err, dout}
  logic [32:0] grant_q[$];  // {mem_rd, mem_addr, mem_din}
  logic [15:0] mem_arr [logic [15:0]];
  int  cur_wait  = 0;
  bit  ack_en    = 1'b1;
  bit  stray_ack = 1'b0;
  int  busy_n    = 0;

  function automatic void check(string name, logic [47:0] act, logic [47:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory responder and completion monitor, both on the falling edge.
  initial begin
    logic [17:0] e;
    logic [32:0] g;
    mem_ack  = 1'b0;
    mem_dout = 16'h0000;
    forever begin
      @(negedge clk);
      if (complete_instr || complete_data) begin
        if (exp_q.size() == 0) begin
          check("unexpected_complete", {complete_instr, complete_data}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("complete_port", {complete_instr, complete_data}, e[17] ? 2'b01 : 2'b10);
          check("mem_err", mem_err, e[16]);
          check("dout", e[17] ? Data_dout : Instr_dout, e[15:0]);
        end
      end else if (mem_err) begin
        check("stray_err", mem_err, 1'b0);
      end

      mem_ack = 1'b0;
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_dout  = 16'hDEAD;
        stray_ack = 1'b0;
      end else if (mem_req) begin
        if (busy_n == 0) begin
          if (grant_q.size() == 0) begin
            check("unexpected_grant", mem_req, 1'b0);
          end else begin
            g = grant_q.pop_front();
            check("grant", {mem_rd, mem_addr, mem_din}, g);
          end
        end
        if (ack_en && busy_n == cur_wait) begin
          mem_ack  = 1'b1;
          mem_dout = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 16'h0000;
        end
        busy_n++;
      end else begin
        busy_n = 0;
      end
    end
  end

  // Vector table
  typedef struct {
    bit          is_data;
    bit          rd;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] rdata;
    int          waits;
    logic [15:0] exp_dout;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[10];

  // Driver: one transaction on one port, request raised in an IDLE cycle.
  task automatic txn(input vec_t v);
    int lat;
    bit done;
    @(negedge clk);
    if (v.rd || !v.is_data) mem_arr[v.addr] = v.rdata;
    cur_wait = v.waits;
    grant_q.push_back({(v.is_data ? v.rd : 1'b1), v.addr, (v.is_data ? v.din : 16'h0000)});
    exp_q.push_back({v.is_data, v.exp_err, v.exp_dout});
    if (v.is_data) begin
      data_req  = 1'b1;
      data_rd   = v.rd;
      data_addr = v.addr;
      data_din  = v.din;
    end else begin
      instr_req  = 1'b1;
      instr_addr = v.addr;
    end
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (v.is_data ? complete_data : complete_instr) done = 1'b1;
    end
    if (v.is_data) data_req = 1'b0;
    else           instr_req = 1'b0;
    check("latency", lat, v.exp_lat);
    check("mem_req_low_at_complete", mem_req, 1'b0);
  endtask

  task automatic wait_complete(input bit is_data, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      if (is_data ? complete_data : complete_instr) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int n_data;
    int n;
    bit instr_done;

    //                is_data rd  addr      din       rdata     waits   exp_dout  err lat
    tbl[0] = '{1'b0, 1'b1, 16'h3000, 16'h0000, 16'h1234, 0,      16'h1234, 1'b0, 2};
    tbl[1] = '{1'b1, 1'b1, 16'h4010, 16'h0000, 16'hA5A5, 0,      16'hA5A5, 1'b0, 2};
    tbl[2] = '{1'b1, 1'b0, 16'h4020, 16'h1111, 16'h0000, 1,      16'hA5A5, 1'b0, 3};
    tbl[3] = '{1'b0, 1'b1, 16'h3001, 16'h0000, 16'h5678, 3,      16'h5678, 1'b0, 5};
    tbl[4] = '{1'b1, 1'b1, 16'h4030, 16'h0000, 16'h0F0F, 2,      16'h0F0F, 1'b0, 4};
    tbl[5] = '{1'b0, 1'b1, 16'h3002, 16'h0000, 16'h9ABC, 63,     16'h9ABC, 1'b0, 65};
    tbl[6] = '{1'b1, 1'b1, 16'h4040, 16'h0000, 16'h7777, NO_ACK, 16'h0000, 1'b1, 65};
    tbl[7] = '{1'b1, 1'b0, 16'h4050, 16'hCAFE, 16'h0000, NO_ACK, 16'h0000, 1'b1, 65};
    tbl[8] = '{1'b0, 1'b1, 16'h3003, 16'h0000, 16'hFFFF, 0,      16'hFFFF, 1'b0, 2};
    tbl[9] = '{1'b1, 1'b1, 16'h4060, 16'h0000, 16'h2468, 0,      16'h2468, 1'b0, 2};

    rst        = 1'b1;
    instr_req  = 1'b0;
    instr_addr = 16'h0000;
    data_req   = 1'b0;
    data_rd    = 1'b0;
    data_addr  = 16'h0000;
    data_din   = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_outputs", {complete_instr, complete_data, mem_req, mem_rd, mem_err},
          5'b00000);
    check("rst_douts", {Instr_dout, Data_dout, mem_addr, mem_din}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) txn(tbl[i]);

    // Both requests at once: data write first, then the fetch.
    @(negedge clk);
    mem_arr[16'h3100] = 16'h4321;
    cur_wait = 0;
    grant_q.push_back({1'b0, 16'h4000, 16'hBEEF});
    grant_q.push_back({1'b1, 16'h3100, 16'h0000});
    exp_q.push_back({1'b1, 1'b0, 16'h2468});
    exp_q.push_back({1'b0, 1'b0, 16'h4321});
    instr_req  = 1'b1;
    instr_addr = 16'h3100;
    data_req   = 1'b1;
    data_rd    = 1'b0;
    data_addr  = 16'h4000;
    data_din   = 16'hBEEF;
    wait_complete(1'b1, ok);
    check("simul_data_done", ok, 1'b1);
    data_req = 1'b0;
    wait_complete(1'b0, ok);
    check("simul_instr_done", ok, 1'b1);
    instr_req = 1'b0;

    // Starvation guard: data held high, fetch waiting -> D, D, D, I, D.
    @(negedge clk);
    for (int i = 0; i < 4; i++) mem_arr[16'h4100 + 16'(i)] = 16'h6000 + 16'(i);
    mem_arr[16'h3200] = 16'h1357;
    cur_wait = 1;
    for (int i = 0; i < 3; i++) begin
      grant_q.push_back({1'b1, 16'h4100 + 16'(i), 16'h0000});
      exp_q.push_back({1'b1, 1'b0, 16'h6000 + 16'(i)});
    end
    grant_q.push_back({1'b1, 16'h3200, 16'h0000});
    exp_q.push_back({1'b0, 1'b0, 16'h1357});
    grant_q.push_back({1'b1, 16'h4103, 16'h0000});
    exp_q.push_back({1'b1, 1'b0, 16'h6003});
    instr_req  = 1'b1;
    instr_addr = 16'h3200;
    data_req   = 1'b1;
    data_rd    = 1'b1;
    data_addr  = 16'h4100;
    data_din   = 16'h0000;
    n_data     = 0;
    instr_done = 1'b0;
    n          = 0;
    while ((n_data < 4 || !instr_done) && n < 300) begin
      @(negedge clk);
      n++;
      if (complete_data) begin
        n_data++;
        data_addr = 16'h4100 + 16'(n_data);
        if (n_data == 4) data_req = 1'b0;
      end
      if (complete_instr) begin
        instr_done = 1'b1;
        instr_req  = 1'b0;
      end
    end
    check("starve_seq_done", {instr_done, 8'(n_data)}, {1'b1, 8'd4});
    data_req  = 1'b0;
    instr_req = 1'b0;

    // Reset in the third BUSY cycle, then a stray ack.
    @(negedge clk);
    ack_en = 1'b0;
    grant_q.push_back({1'b1, 16'h3300, 16'h0000});
    instr_req  = 1'b1;
    instr_addr = 16'h3300;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reset_seq_busy", mem_req, 1'b1);
    repeat (2) @(negedge clk);
    rst       = 1'b1;
    instr_req = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {complete_instr, complete_data, mem_req, mem_rd, mem_err},
          5'b00000);
    check("midrst_douts", {Instr_dout, Data_dout, mem_addr, mem_din}, 64'h0);
    rst       = 1'b0;
    stray_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_ack_ignored", {mem_req, Instr_dout}, 17'h0);
    ack_en = 1'b1;
    txn('{1'b0, 1'b1, 16'h3400, 16'h0000, 16'h8642, 1, 16'h8642, 1'b0, 3});

    repeat (3) @(negedge clk);
    check("queues_drained", exp_q.size() + grant_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Single-port memory arbiter that lets the LC3 core's instruction-fetch and data-access channels share one unified memory. It sits between the core's instruction and data handshakes and a single memory port. It serialises requests with data priority plus an instruction anti-starvation guard, and it aborts transactions that are never acknowledged.

## Interface
Parameters:
- STARVE_LIMIT, 3, consecutive data grants allowed while instr_req is pending before instr is forced
- TIMEOUT, 64, BUSY cycles without mem_ack before abort (≥2)

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- instr_req  in  1  fetch request, level, held until complete_instr
- instr_addr  in  16  fetch address (PC)
- complete_instr  out  1  one-cycle fetch-done pulse
- Instr_dout  out  16  last fetched word, held
- data_req  in  1  data request, level, held until complete_data
- data_rd  in  1  1 = read, 0 = write
- data_addr  in  16  data address
- data_din  in  16  write data
- complete_data  out  1  one-cycle data-done pulse
- Data_dout  out  16  last read word, held
- mem_req  out  1  memory request, high through BUSY
- mem_rd  out  1  1 = read, 0 = write
- mem_addr  out  16  latched address
- mem_din  out  16  latched write data
- mem_dout  in  16  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- mem_err  out  1  one-cycle pulse with the complete_* of an aborted transaction

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: choose a port.
  - If both requests are high, data wins unless starve_cnt == STARVE_LIMIT; then instr wins.
  - Latch port id, address, rd flag and write data into mem_* registers, then go to BUSY.
  - Instr grants are always reads.
- BUSY: mem_req=1 and wait_cnt increments.
  - mem_ack=1: latch mem_dout into the granted port's dout (reads only), then go to RESP.
  - wait_cnt == TIMEOUT-1 without ack: abort, go to RESP with err flag set, and load 16'h0000 into the granted read port's dout.
- RESP: pulse complete_instr or complete_data (exactly one), plus mem_err if aborted, then go to IDLE. Requests are not sampled in RESP.
- starve_cnt:
  - Increments on each data grant made while instr_req=1.
  - Clears on an instr grant, or on any IDLE cycle with instr_req=0.
  - Saturates at STARVE_LIMIT.
- A write completion leaves Data_dout unchanged.
- mem_ack outside BUSY is ignored. Request changes during BUSY/RESP are ignored.
- Width rules: starve_cnt is $clog2(STARVE_LIMIT+1) bits; wait_cnt is $clog2(TIMEOUT) bits. Neither wraps.

## Timing
- Every output registered.
- Reset values: state IDLE; all outputs 0, including Instr_dout and Data_dout = 16'h0000; counters 0.
- Zero-wait memory: request seen in IDLE at cycle 0 → mem_req=1 in cycle 1 → mem_ack in cycle 1 → complete in cycle 2 → IDLE in cycle 3.
  - Request-to-complete latency is 2 cycles; occupancy is 3 cycles.
- Each additional memory wait cycle adds one cycle of latency.
- dout is valid from the complete cycle and held until the next read completion on the same port.
- Requester contract: drop req no later than the cycle after complete. Re-raising req in that cycle is a new request.
- mem_ack arriving in the same cycle wait_cnt reaches TIMEOUT-1 counts as success; no error.
- rst during BUSY or RESP: next cycle is IDLE with all outputs and counters cleared; no complete pulse; a later stray mem_ack is ignored.

## Structure
- Package lc3_mem_pkg holds:
  - WORD_W = 16
  - enum arb_state_t {IDLE, BUSY, RESP}
  - enum mem_port_t {PORT_INSTR, PORT_DATA}
- Sub-module lc3_mem_wait_timer (clk, rst, run, expire) holds the TIMEOUT counter.
- Arbitration and datapath latches live in the top.

## Test plan
- Single fetch: instr_req, instr_addr=16'h3000, mem_ack in first BUSY cycle with mem_dout=16'h1234 → complete_instr in cycle 2, Instr_dout=16'h1234, mem_err=0.
- Simultaneous requests: both high, data write addr 16'h4000 din 16'hBEEF → data granted first, mem_rd=0, mem_din=16'hBEEF; Data_dout unchanged; instr served in the next transaction.
- Starvation guard: instr_req held high, data_req re-raised every IDLE, STARVE_LIMIT=3 → grants go data, data, data, instr.
- Timeout: data read with mem_ack never asserted, TIMEOUT=64 → complete_data and mem_err pulse together 65 cycles after the request cycle; Data_dout=16'h0000; mem_req low after abort.
- Reset mid-BUSY: rst in the third wait cycle, then mem_ack → no complete pulse; outputs zero; arbiter IDLE and serves a new fetch normally.
- Boundary ack: mem_ack exactly on wait_cnt=TIMEOUT-1 → normal completion, mem_err=0, read data captured.
